// File: rtl/ssp_tx_arbiter_if.sv
// ssp_tx_arbiter_if
//   Bundles the producer-side handshake and the TX FIFO write side of the
//   SSP transmit arbiter.
//
//   Handshake: a producer raises req[i] with its word on wdata[i*WIDTH +: WIDTH]
//   and holds both stable until gnt[i] is seen. gnt[i] is a one-cycle
//   acknowledge that the word was written to the TX FIFO on that same cycle
//   (txfifowrite=1, txwdata=word). txfifofull=1 means the FIFO cannot accept
//   a word; the arbiter issues no grant while it is high.
//
//   master : the arbiter (drives gnt/txfifowrite/txwdata/owner/busy)
//   slave  : producers + TX FIFO (drive enable/req/lock/wdata/txfifofull)
interface ssp_tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic                     enable;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          lock;
  logic [NREQ*WIDTH-1:0]    wdata;
  logic                     txfifofull;
  logic [NREQ-1:0]          gnt;
  logic                     txfifowrite;
  logic [WIDTH-1:0]         txwdata;
  logic [$clog2(NREQ)-1:0]  owner;
  logic                     busy;

  modport master (
    input  enable, req, lock, wdata, txfifofull,
    output gnt, txfifowrite, txwdata, owner, busy
  );

  modport slave (
    output enable, req, lock, wdata, txfifofull,
    input  gnt, txfifowrite, txwdata, owner, busy
  );
endinterface

// File: rtl/ssp_tx_arbiter.sv
// ssp_tx_arbiter
//   Round-robin arbiter sharing the SSP TX FIFO between NREQ word producers,
//   with a bounded burst lock so one producer can send up to MAXBURST
//   consecutive words. At most one word per two pclk cycles (IDLE -> GRANT).
//
//   Ports:
//     pclk      : clock, all logic on posedge
//     clear     : synchronous active-high reset
//     bus       : ssp_tx_arbiter_if.master (enable, req, lock, wdata,
//                 txfifofull in; gnt, txfifowrite, txwdata, owner, busy out)
//     state_dbg : current FSM state (0=IDLE, 1=GRANT)
//
//   All outputs are registered.
module ssp_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                    pclk,
  input  logic                    clear,
  ssp_tx_arbiter_if.master        bus,
  output logic                    state_dbg
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [WIDTH-1:0]  txw_q, txw_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              found;
  int                win_i;
  int                idx;

  // Rotating priority search starting at ptr. Iterating from the farthest
  // offset down to offset 0 lets the closest requester overwrite the others.
  always_comb begin
    found = 1'b0;
    win_i = 0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) begin
        found = 1'b1;
        win_i = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    wr_d    = 1'b0;
    txw_d   = txw_q;
    owner_d = owner_q;
    busy_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && !bus.txfifofull && found) begin
          state_d      = GRANT;
          gnt_d[win_i] = 1'b1;
          wr_d         = 1'b1;
          txw_d        = bus.wdata[win_i*WIDTH +: WIDTH];
          owner_d      = PW'(win_i);
          busy_d       = 1'b1;
          // owner_q still holds the previous grantee here.
          if (bus.lock[win_i] && (PW'(win_i) == owner_q) &&
              (int'(cnt_q) + 1 < MAXBURST)) begin
            ptr_d = PW'(win_i);
            cnt_d = cnt_q + CW'(1);
          end else if (bus.lock[win_i] && (PW'(win_i) != owner_q)) begin
            cnt_d = CW'(1);
            if (MAXBURST > 1) ptr_d = PW'(win_i);
            else              ptr_d = (win_i == NREQ - 1) ? '0 : PW'(win_i + 1);
          end else begin
            cnt_d = '0;
            ptr_d = (win_i == NREQ - 1) ? '0 : PW'(win_i + 1);
          end
        end
      end
      GRANT: begin
        // Requests seen during GRANT are ignored; the strobes drop next cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (clear) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      txw_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      txw_q   <= txw_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.txfifowrite = wr_q;
  assign bus.txwdata     = txw_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign state_dbg       = state_q;
endmodule

// File: doc/ssp_tx_arbiter.md
Name: ssp_tx_arbiter

Overview:
- Round-robin arbiter that shares the SSP transmit path between NREQ word producers.
- Each cycle it selects at most one requester and writes that requester's 8-bit word into the TX FIFO that feeds the serial talker.
- It respects TX FIFO back-pressure and a global enable.
- It supports a bounded burst lock, so one producer can send consecutive words without interleaving.

Parameters:
- NREQ, 4: number of requesters. Legal range is 2..8.
- WIDTH, 8: word width in bits. Matches the SSP word.
- MAXBURST, 4: maximum consecutive grants to one locking requester before forced rotation. Legal range is >= 1.

Ports:
- pclk  input  1  SSP system clock; all logic on posedge.
- clear  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new grants are issued.
- req  input  NREQ  per-requester word-valid; bit i belongs to requester i.
- lock  input  NREQ  per-requester burst-lock hint. Sampled together with the granted word.
- wdata  input  NREQ*WIDTH  requester i word on bits [i*WIDTH +: WIDTH].
- txfifofull  input  1  TX FIFO cannot accept a word this cycle.
- gnt  output  NREQ  one-hot, one-cycle acknowledge of the accepted word.
- txfifowrite  output  1  TX FIFO write strobe.
- txwdata  output  WIDTH  word written to the TX FIFO.
- owner  output  clog2(NREQ)  index of the current or last grantee.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (clear=1 at posedge) has priority over all other inputs. It sets:
  - state=IDLE, gnt=0, txfifowrite=0, txwdata=0, owner=0, busy=0
  - ptr=0, burstcnt=0
- Reset mid-GRANT: outputs are 0 in the next cycle. A word written in the final GRANT cycle is not retracted; the FIFO owner resets it.
- All outputs are registered; there is no combinational path from input to output.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - The arbiter considers a grant only when enable=1, txfifofull=0 and |req != 0.
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - On a win, at the next posedge: state=GRANT, gnt[winner]=1, txfifowrite=1, txwdata=wdata[winner], owner=winner, busy=1.
  - Latency: req sampled at edge N produces gnt and txfifowrite high for the cycle after edge N.
- GRANT:
  - gnt, txfifowrite and busy are high for exactly one cycle.
  - At the next posedge: state=IDLE and gnt=txfifowrite=busy=0. txwdata and owner hold their values.
  - req sampled during GRANT is ignored. This gives the requester the GRANT cycle to drop req or present its next word.
  - Maximum throughput is one word per 2 pclk.
- Handshake rules for requesters:
  - Hold req and wdata stable until gnt is seen.
  - req must not be retracted before gnt. If it is, the arbiter simply does not pick that requester; no error is flagged.
- Pointer and burst update, applied on every grant to winner w:
  - If lock[w]=1 and w==owner_prev and burstcnt+1 < MAXBURST: ptr stays w, burstcnt increments.
  - If lock[w]=1 and w!=owner_prev: burstcnt=1, and ptr=w if MAXBURST>1, else ptr=(w+1) mod NREQ.
  - Otherwise (lock low, or burst limit reached): ptr=(w+1) mod NREQ, burstcnt=0.
- Burst interruption: if the locked requester drops req, the round-robin search naturally passes it. The next grant goes to another requester and restarts burstcnt.
- txfifofull=1 or enable=0 in IDLE: stay in IDLE. No outputs change; ptr and burstcnt hold.
- enable falling during GRANT: the GRANT cycle completes normally.
- Simultaneous requests: only the requester that the pointer search reaches first wins. All others wait; there is no starvation because of the bounded burst.
- Wrap-around: the search index and ptr use modulo NREQ arithmetic.

Test Plan:
- Reset and single requester:
  - Stimulus: clear 2 cycles, then req=0001, wdata[0]=8'hA5, lock=0.
  - Response: one cycle later gnt=0001, txfifowrite=1, txwdata=A5, owner=0. The next cycle all strobes are low.
- Round-robin fairness:
  - Stimulus: req=1111 held for 8 grants, lock=0.
  - Response: grant order is 0,1,2,3,0,1,2,3 with txfifowrite every other cycle.
- Burst lock limit:
  - Stimulus: req=0011, lock[1]=1, MAXBURST=4, after requester 1 first wins.
  - Response: grant order is 1,1,1,1,0,1,1,1,1,0.
- Back-pressure:
  - Stimulus: req=0100 with txfifofull=1 for 5 cycles, then 0.
  - Response: no gnt while full. gnt=0100 exactly one cycle after full drops; txwdata equals the held wdata[2].
- Enable and reset mid-operation:
  - Stimulus: enable=0 with req=1000 → no grant. Then enable=1 → grant to 3. Then clear asserted during the GRANT cycle.
  - Response: all outputs are 0 the next cycle, and ptr=0 (next winner with req=1001 is 0).
- Wrap-around:
  - Stimulus: last grant owner=3, lock=0, req=1001.
  - Response: next grant goes to 0, then to 3.
